avalon_led_pio: RTL and testbench
=================================

// Module: avalon_led_pio
// PURPOSE
//   Avalon-MM slave (responder) that drives the board LEDs; output-direction counterpart of the key input PIO.
//   Sits inside nios_system on the Nios II data master; leds_export routes to {LEDR,LEDG} at the top level.
//   Adds set/clear registers and a hardware blink engine, so software can flash LEDs without polling a timer.
// PARAMETERS
//   WIDTH         26          LED count (18 red + 8 green); 1..32
//   PERIOD_RESET  25_000_000  reset value of BLINK_PERIOD (half-period in clocks; 0.5 s at 50 MHz)
// PORTS
//   clk_clk            in   1      system clock (50 MHz)
//   reset_reset_n      in   1      asynchronous, active-low reset
//   avs_address        in   3      word address
//   avs_read           in   1      read strobe
//   avs_write          in   1      write strobe
//   avs_writedata      in   32     write data
//   avs_byteenable     in   4      byte lanes for writes
//   avs_readdata       out  32     read data, valid with avs_readdatavalid
//   avs_readdatavalid  out  1      one-cycle pulse, read latency 1
//   avs_waitrequest    out  1      tied 0; every access accepted in its cycle
//   leds_export        out  WIDTH  LED drive, 1 = lit
// BEHAVIOUR
//   Register map (word addresses):
//     0 DATA   RW  LED base pattern
//     1 SET    WO  DATA |= wdata; reads 0
//     2 CLR    WO  DATA &= ~wdata; reads 0
//     3 MASK   RW  bits that blink
//     4 PERIOD RW  blink half-period in clocks, 32 b; 0 = blink off
//     5 STATUS RO  bit0 = phase, bits31:1 = counter[30:0]
//     6,7      reads 0, writes ignored
//   Writes: only bytes with byteenable=1 are updated (for SET/CLR, masked-off bytes have no effect).
//     DATA/MASK bits at or above WIDTH are not stored and read 0.
//   Reads: avs_readdata is registered; valid the cycle after avs_read, with avs_readdatavalid=1 for exactly 1 cycle.
//     avs_readdata holds its last value otherwise.
//   Read and write in the same cycle: the write is performed; the read returns the pre-write value.
//   Blink engine: 32-bit counter cnt, phase bit ph.
//     PERIOD==0: cnt=0, ph=0 held.
//     Else each clock: if cnt==PERIOD-1 then cnt<=0 and ph<=~ph, else cnt<=cnt+1.
//     Any write to PERIOD (any byteenable) forces cnt<=0, ph<=0 the same edge.
//     Lowering PERIOD below the current cnt therefore cannot skip the wrap.
//   leds_export = DATA ^ (MASK & {WIDTH{ph}}), combinational from registers; visible one clock after the write edge.
//   Reset (async assert, any time, including mid-read):
//     DATA=0, MASK=0, PERIOD=PERIOD_RESET, cnt=0, ph=0;
//     avs_readdata=0, avs_readdatavalid=0, leds_export=0.
//     A read pending at reset returns no readdatavalid.
// TESTING
//   1 Reset release: no access -> leds_export=0, read addr4 -> 0x017D7840, readdatavalid exactly 1 clk after read.
//   2 Write DATA=0xFFFF_FFFF be=4'b0011 -> DATA=0x0000FFFF.
//     Then SET 0x00030000 -> 0x0003FFFF, then CLR 0x0000000F -> 0x0003FFF0.
//     Check on leds_export and on readback.
//   3 Write PERIOD=4, MASK=0x1, DATA=0 -> leds_export[0] toggles every 4 clocks (4 high, 4 low); STATUS phase tracks it.
//   4 With PERIOD=4, write PERIOD=0 mid-count -> ph=0, leds_export[0]=0, STATUS=0 held for 100 clocks.
//   5 Same-cycle read+write of DATA (old 0x5, new 0xA) -> readdata=0x5, next read returns 0xA.
//     Read of addr 1, 2, 6 or 7 returns 0.
//   6 Assert reset_reset_n=0 between read and readdatavalid -> no valid pulse, all outputs 0 asynchronously.

Source files
------------

// File: rtl/avalon_led_pio.sv
// Avalon-MM LED output PIO: DATA/SET/CLR/MASK registers plus a blink engine
// that XORs a toggling phase into the masked LEDs. Read latency 1, no waits.
module avalon_led_pio #(
   parameter int          WIDTH        = 26,
   parameter logic [31:0] PERIOD_RESET = 32'd25_000_000
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [2:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   input  logic [3:0]       avs_byteenable,
   output logic [31:0]      avs_readdata,
   output logic             avs_readdatavalid,
   output logic             avs_waitrequest,
   output logic [WIDTH-1:0] leds_export
);

   // Bits at or above WIDTH are forced to zero so they never hold state.
   localparam logic [31:0] WMASK = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                 : ((32'd1 << WIDTH) - 32'd1);

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_SET    = 3'd1;
   localparam logic [2:0] A_CLR    = 3'd2;
   localparam logic [2:0] A_MASK   = 3'd3;
   localparam logic [2:0] A_PERIOD = 3'd4;
   localparam logic [2:0] A_STATUS = 3'd5;

   logic [31:0] data_q, data_d;
   logic [31:0] mask_q, mask_d;
   logic [31:0] period_q, period_d;
   logic [31:0] cnt_q, cnt_d;
   logic        ph_q, ph_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rd_mux;
   logic [31:0] be_bits;

   // Replace only the byte lanes selected by byteenable.
   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction

   // Read mux over current (pre-write) register values.
   always_comb begin
      rd_mux = 32'd0;
      case (avs_address)
         A_DATA:   rd_mux = data_q;
         A_MASK:   rd_mux = mask_q;
         A_PERIOD: rd_mux = period_q;
         A_STATUS: rd_mux = {cnt_q[30:0], ph_q};
         default:  rd_mux = 32'd0;
      endcase
   end

   // Register writes, blink counter and registered read response.
   always_comb begin
      data_d   = data_q;
      mask_d   = mask_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      ph_d     = ph_q;
      be_bits  = be_merge(32'd0, avs_writedata, avs_byteenable);

      // Free-running blink engine; period 0 parks it.
      if (period_q == 32'd0) begin
         cnt_d = 32'd0;
         ph_d  = 1'b0;
      end else if (cnt_q == period_q - 32'd1) begin
         cnt_d = 32'd0;
         ph_d  = ~ph_q;
      end else begin
         cnt_d = cnt_q + 32'd1;
      end

      if (avs_write) begin
         case (avs_address)
            A_DATA: data_d = be_merge(data_q, avs_writedata, avs_byteenable) & WMASK;
            A_SET:  data_d = (data_q | be_bits) & WMASK;
            A_CLR:  data_d = data_q & ~be_bits;
            A_MASK: mask_d = be_merge(mask_q, avs_writedata, avs_byteenable) & WMASK;
            A_PERIOD: begin
               // Restart from a clean phase so a smaller period cannot skip the wrap.
               period_d = be_merge(period_q, avs_writedata, avs_byteenable);
               cnt_d    = 32'd0;
               ph_d     = 1'b0;
            end
            default: ;
         endcase
      end

      rvalid_d = avs_read;
      rdata_d  = avs_read ? rd_mux : rdata_q;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         data_q   <= 32'd0;
         mask_q   <= 32'd0;
         period_q <= PERIOD_RESET;
         cnt_q    <= 32'd0;
         ph_q     <= 1'b0;
         rdata_q  <= 32'd0;
         rvalid_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         mask_q   <= mask_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         ph_q     <= ph_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign avs_readdata      = rdata_q;
   assign avs_readdatavalid = rvalid_q;
   assign avs_waitrequest   = 1'b0;
   assign leds_export       = data_q[WIDTH-1:0] ^ (mask_q[WIDTH-1:0] & {WIDTH{ph_q}});

endmodule

// File: tb/tb_avalon_led_pio.sv
// Directed bench for avalon_led_pio. Inputs change on falling edges, outputs
// are sampled on falling edges; read expectations go through a scoreboard queue.
module tb_avalon_led_pio;

   localparam int W = 26;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [2:0]    addr;
   logic          rd, wr;
   logic [31:0]   wdata;
   logic [3:0]    be;
   logic [31:0]   rdata;
   logic          rvalid, waitreq;
   logic [W-1:0]  leds;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] sb[$];

   avalon_led_pio #(.WIDTH(W), .PERIOD_RESET(32'd25_000_000)) dut (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .avs_address(addr), .avs_read(rd), .avs_write(wr),
      .avs_writedata(wdata), .avs_byteenable(be),
      .avs_readdata(rdata), .avs_readdatavalid(rvalid),
      .avs_waitrequest(waitreq), .leds_export(leds)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pop the oldest expected read value and compare with readdata.
   task automatic sb_check(input string tag);
      logic [31:0] e;
      if (sb.size() == 0) begin
         n_cmp++; n_err++;
         $error("FAIL %s: observed %h expected <empty scoreboard>", tag, rdata);
      end else begin
         e = sb.pop_front();
         chk(tag, rdata, e);
      end
   endtask

   // Called on a falling edge; returns one falling edge later.
   task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
      addr = a; wdata = d; be = b; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0; be = 4'h0;
   endtask

   // Called on a falling edge; checks a single-cycle valid pulse; returns two edges later.
   task automatic do_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
      addr = a; rd = 1'b1;
      sb.push_back(exp);
      @(negedge clk);
      rd = 1'b0;
      chk({tag, "_vld"}, {31'd0, rvalid}, 32'd1);
      sb_check(tag);
      @(negedge clk);
      chk({tag, "_vld_off"}, {31'd0, rvalid}, 32'd0);
   endtask

   initial begin
      int k;
      rst_n = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0; be = '0;
      repeat (3) @(negedge clk);
      chk("rst_leds",   {6'd0, leds}, 32'd0);
      chk("rst_vld",    {31'd0, rvalid}, 32'd0);
      chk("rst_rdata",  rdata, 32'd0);
      chk("waitreq",    {31'd0, waitreq}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: reset values and read latency
      chk("t1_leds", {6'd0, leds}, 32'd0);
      chk("t1_vld_idle", {31'd0, rvalid}, 32'd0);
      do_read("t1_period", 3'd4, 32'h017D_7840);
      do_read("t1_data", 3'd0, 32'd0);

      // 2: byte enables, SET, CLR, truncation above WIDTH
      do_write(3'd0, 32'hFFFF_FFFF, 4'b0011);
      chk("t2_leds_be", {6'd0, leds}, 32'h0000_FFFF);
      do_read("t2_rd_be", 3'd0, 32'h0000_FFFF);
      do_write(3'd1, 32'h0003_0000, 4'hF);
      chk("t2_leds_set", {6'd0, leds}, 32'h0003_FFFF);
      do_read("t2_rd_set", 3'd0, 32'h0003_FFFF);
      do_write(3'd2, 32'h0000_000F, 4'hF);
      chk("t2_leds_clr", {6'd0, leds}, 32'h0003_FFF0);
      do_read("t2_rd_clr", 3'd0, 32'h0003_FFF0);
      do_write(3'd1, 32'h0F00_0000, 4'b0111);
      do_read("t2_set_masked", 3'd0, 32'h0003_FFF0);
      do_write(3'd2, 32'h0000_00F0, 4'b1110);
      do_read("t2_clr_masked", 3'd0, 32'h0003_FFF0);
      do_write(3'd0, 32'hFFFF_FFFF, 4'hF);
      do_read("t2_trunc_data", 3'd0, 32'h03FF_FFFF);
      do_write(3'd3, 32'hFFFF_FFFF, 4'hF);
      do_read("t2_trunc_mask", 3'd3, 32'h03FF_FFFF);

      // 3: blink with PERIOD=4 on bit 0
      do_write(3'd3, 32'h1, 4'hF);
      do_write(3'd0, 32'h0, 4'hF);
      do_write(3'd4, 32'd4, 4'hF);
      k = 0;
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("t3_led_k%0d", k), {6'd0, leds}, ((k / 4) % 2 == 1) ? 32'd1 : 32'd0);
         @(negedge clk); k++;
      end
      do_read("t3_status_a", 3'd5, (32'(k % 4) << 1) | 32'((k / 4) % 2)); k += 2;
      do_read("t3_status_b", 3'd5, (32'(k % 4) << 1) | 32'((k / 4) % 2)); k += 2;
      while (k < 30) begin @(negedge clk); k++; end
      chk("t3_led_pre_stop", {6'd0, leds}, 32'd1);

      // 4: PERIOD=0 mid-count parks phase low
      do_write(3'd4, 32'd0, 4'b0001);
      for (int i = 0; i < 50; i++) begin
         chk("t4_led", {6'd0, leds}, 32'd0);
         do_read("t4_status", 3'd5, 32'd0);
      end
      do_read("t4_period", 3'd4, 32'd0);

      // 5: same-cycle read and write returns old value; unmapped reads
      do_write(3'd0, 32'h5, 4'hF);
      addr = 3'd0; wdata = 32'hA; be = 4'hF; wr = 1'b1; rd = 1'b1;
      sb.push_back(32'h5);
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      chk("t5_rw_vld", {31'd0, rvalid}, 32'd1);
      sb_check("t5_rw_old");
      @(negedge clk);
      do_read("t5_new", 3'd0, 32'hA);
      do_write(3'd6, 32'hDEAD_BEEF, 4'hF);
      do_read("t5_a1", 3'd1, 32'd0);
      do_read("t5_a2", 3'd2, 32'd0);
      do_read("t5_a6", 3'd6, 32'd0);
      do_read("t5_a7", 3'd7, 32'd0);
      do_read("t5_after_a6", 3'd0, 32'hA);

      // 6: reset asserted while a read is in flight
      do_write(3'd0, 32'h00AB_CDEF, 4'hF);
      do_read("t6_pre", 3'd0, 32'h00AB_CDEF);
      addr = 3'd0; rd = 1'b1;
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      chk("t6_async_leds",  {6'd0, leds}, 32'd0);
      chk("t6_async_rdata", rdata, 32'd0);
      chk("t6_async_vld",   {31'd0, rvalid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rd = 1'b0;
         chk("t6_no_vld", {31'd0, rvalid}, 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_post_vld", {31'd0, rvalid}, 32'd0);
      do_read("t6_post_data", 3'd0, 32'd0);
      do_read("t6_post_period", 3'd4, 32'h017D_7840);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
